// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
// spi_arb_pkg : shared state encoding and requester count for spi_req_arbiter
// Revision    : 1.0
// ============================================================================
package spi_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// spi_arb_rr_pick : combinational 2-way round-robin picker, one-hot grant
// Revision        : 1.0
// ============================================================================
module spi_arb_rr_pick
  import spi_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_grant,
  output logic [NUM_REQ-1:0] grant
);

  // A lone request wins outright; a tie goes to whoever was not served last.
  always_comb begin
    grant = req;
    if (&req) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_req_arbiter.sv
`default_nettype none
// ============================================================================
// spi_req_arbiter : round-robin sharing of one SPI master between two sources
//                   Optional WAIT watchdog enabled by macro SPI_ARB_TIMEOUT_EN
// Revision        : 1.0
// ============================================================================
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int SPI_ADDR_WIDTH = 6,
  parameter int SPI_DATA_WIDTH = 20,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          i_clk_sys,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_req_rw,
  input  logic [2*SPI_ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [2*SPI_DATA_WIDTH-1:0]   i_req_wdata,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic                          o_err,
  output logic [SPI_DATA_WIDTH-1:0]     o_rdata,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_spi_start,
  output logic                          o_spi_rw,
  output logic [SPI_ADDR_WIDTH-1:0]     o_spi_addr,
  output logic [SPI_DATA_WIDTH-1:0]     o_spi_wdata,
  input  logic                          i_spi_done,
  input  logic [SPI_DATA_WIDTH-1:0]     i_spi_rdata
);

  arb_state_t         state;
  logic               last_grant;
  logic [NUM_REQ-1:0] pick;
  logic               win_idx;
  logic               expire;

  spi_arb_rr_pick u_pick (
    .req        (i_req),
    .last_grant (last_grant),
    .grant      (pick)
  );

  assign win_idx = pick[1];

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wait_cnt;

  assign expire = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter is zeroed in ISSUE so it reads 0 in the first WAIT cycle.
  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      wait_cnt <= '0;
      o_err    <= 1'b0;
    end else begin
      o_err <= (state == ST_WAIT) && !i_spi_done && expire;
      if (state == ST_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  // The watchdog limit has no effect when the watchdog is compiled out.
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign expire             = 1'b0;
  assign o_err              = 1'b0;
`endif

  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      last_grant  <= 1'b1;
      o_ack       <= '0;
      o_rdata     <= '0;
      o_grant     <= '0;
      o_spi_start <= 1'b0;
      o_spi_rw    <= 1'b0;
      o_spi_addr  <= '0;
      o_spi_wdata <= '0;
    end else begin
      o_spi_start <= 1'b0;
      o_ack       <= '0;
      case (state)
        ST_IDLE: begin
          if (|i_req) begin
            o_grant     <= pick;
            last_grant  <= win_idx;
            o_spi_rw    <= i_req_rw[win_idx];
            o_spi_addr  <= win_idx ? i_req_addr[2*SPI_ADDR_WIDTH-1:SPI_ADDR_WIDTH]
                                   : i_req_addr[SPI_ADDR_WIDTH-1:0];
            o_spi_wdata <= win_idx ? i_req_wdata[2*SPI_DATA_WIDTH-1:SPI_DATA_WIDTH]
                                   : i_req_wdata[SPI_DATA_WIDTH-1:0];
            o_spi_start <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (i_spi_done) begin
            o_rdata <= i_spi_rdata;
            o_ack   <= o_grant;
            state   <= ST_RESP;
          end else if (expire) begin
            o_rdata <= '1;
            o_ack   <= o_grant;
            state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          o_grant <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_req_arbiter.sv
`default_nettype none
// ============================================================================
// tb_spi_req_arbiter : randomized self-checking bench for spi_req_arbiter
// Revision           : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_spi_req_arbiter;

  localparam int AW  = 6;
  localparam int DW  = 20;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req, req_rw;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      ack, grant;
  logic            err;
  logic [DW-1:0]   rdata;
  logic            spi_start, spi_rw;
  logic [AW-1:0]   spi_addr;
  logic [DW-1:0]   spi_wdata;
  logic            spi_done;
  logic [DW-1:0]   spi_rdata;

  int checks = 0;
  int errors = 0;
  int last_win = 1;

  always #5 clk = ~clk;

  spi_req_arbiter #(
    .SPI_ADDR_WIDTH (AW),
    .SPI_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk_sys   (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_req_rw    (req_rw),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_ack       (ack),
    .o_err       (err),
    .o_rdata     (rdata),
    .o_grant     (grant),
    .o_spi_start (spi_start),
    .o_spi_rw    (spi_rw),
    .o_spi_addr  (spi_addr),
    .o_spi_wdata (spi_wdata),
    .i_spi_done  (spi_done),
    .i_spi_rdata (spi_rdata)
  );

  // Round-robin reference: a lone request wins, a tie goes to the other one.
  function automatic int model_winner(input logic [1:0] r, input int last);
    if (r == 2'b11) return (last == 0) ? 1 : 0;
    return (r == 2'b10) ? 1 : 0;
  endfunction

  task automatic set_src(input int n, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_rw[n] = rw;
    if (n == 0) begin
      req_addr[AW-1:0] = a; req_wdata[DW-1:0] = d;
    end else begin
      req_addr[2*AW-1:AW] = a; req_wdata[2*DW-1:DW] = d;
    end
  endtask

  // Acts as the SPI master for one transaction and reports what was seen.
  task automatic serve(input int lat, input logic [DW-1:0] rd, input logic [1:0] clr,
                       output logic [1:0] g, output logic rw, output logic [AW-1:0] a,
                       output logic [DW-1:0] d, output logic [1:0] ack_o, output logic err_o,
                       output logic [DW-1:0] rdata_o, output logic [1:0] grant_after,
                       output int early, output bit tmo);
    int n;
    tmo = 1'b0; early = 0; n = 0;
    g = '0; rw = 1'b0; a = '0; d = '0; ack_o = '0; err_o = 1'b0; rdata_o = '0; grant_after = '0;
    do begin
      @(negedge clk); n++;
    end while (!spi_start && n < 60);
    if (!spi_start) begin
      tmo = 1'b1;
      return;
    end
    g = grant; rw = spi_rw; a = spi_addr; d = spi_wdata;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      if (ack != 2'b00) early++;
    end
    spi_done = 1'b1; spi_rdata = rd;
    @(negedge clk);
    spi_done = 1'b0; spi_rdata = DW'($urandom);
    ack_o = ack; err_o = err; rdata_o = rdata;
    req = req & ~clr;
    @(negedge clk);
    grant_after = grant;
    if (ack != 2'b00) early++;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    spi_done = 1'b0; spi_rdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack, err, rdata, grant, spi_start, spi_rw, spi_addr, spi_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b err=%b rdata=%h grant=%b start=%b rw=%b addr=%h wdata=%h, expected all zero",
               ack, err, rdata, grant, spi_start, spi_rw, spi_addr, spi_wdata);
    end
    rst = 1'b0;
    last_win = 1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    logic [1:0] g, a_o, ga; logic rw, e; logic [AW-1:0] a; logic [DW-1:0] d, r; int early; bit tmo;
    set_src(0, 1'b0, 6'h15, 20'hABCDE);
    req = 2'b01;
    serve(10, 20'h5A5A5, 2'b11, g, rw, a, d, a_o, e, r, ga, early, tmo);
    checks++;
    if (tmo !== 1'b0) begin errors++; $display("FAIL write_start: no o_spi_start seen, expected one"); end
    checks++;
    if ({g, rw, a, d} !== {2'b01, 1'b0, 6'h15, 20'hABCDE}) begin
      errors++; $display("FAIL write_latch: got grant=%b rw=%b addr=%h wdata=%h, expected 01 0 15 abcde", g, rw, a, d);
    end
    checks++;
    if ({a_o, e} !== {2'b01, 1'b0}) begin
      errors++; $display("FAIL write_ack: got ack=%b err=%b, expected 01 0", a_o, e);
    end
    checks++;
    if (early != 0 || ga !== 2'b00) begin
      errors++; $display("FAIL write_framing: got stray_acks=%0d grant_after=%b, expected 0 00", early, ga);
    end
    last_win = 0;
  endtask

  task automatic test_single_read();
    logic [1:0] g, a_o, ga; logic rw, e; logic [AW-1:0] a; logic [DW-1:0] d, r; int early; bit tmo;
    set_src(1, 1'b1, 6'h3F, 20'h00000);
    req = 2'b10;
    serve(4, 20'h12345, 2'b11, g, rw, a, d, a_o, e, r, ga, early, tmo);
    checks++;
    if (tmo || {g, rw, a} !== {2'b10, 1'b1, 6'h3F}) begin
      errors++; $display("FAIL read_latch: got tmo=%0d grant=%b rw=%b addr=%h, expected 0 10 1 3f", tmo, g, rw, a);
    end
    checks++;
    if ({a_o, e, r} !== {2'b10, 1'b0, 20'h12345}) begin
      errors++; $display("FAIL read_data: got ack=%b err=%b rdata=%h, expected 10 0 12345", a_o, e, r);
    end
    last_win = 1;
  endtask

  task automatic test_tie_after_reset();
    logic [1:0] g, a_o, ga; logic rw, e; logic [AW-1:0] a; logic [DW-1:0] d, r; int early; bit tmo;
    rst = 1'b1;
    set_src(0, 1'b0, 6'h01, 20'h11111);
    set_src(1, 1'b1, 6'h02, 20'h22222);
    req = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    last_win = 1;
    serve(3, 20'h0, 2'b01, g, rw, a, d, a_o, e, r, ga, early, tmo);
    checks++;
    if (tmo || {g, a, a_o} !== {2'b01, 6'h01, 2'b01}) begin
      errors++; $display("FAIL tie_first: got tmo=%0d grant=%b addr=%h ack=%b, expected 0 01 01 01", tmo, g, a, a_o);
    end
    serve(2, 20'h0, 2'b11, g, rw, a, d, a_o, e, r, ga, early, tmo);
    checks++;
    if (tmo || {g, a, a_o} !== {2'b10, 6'h02, 2'b10}) begin
      errors++; $display("FAIL tie_second: got tmo=%0d grant=%b addr=%h ack=%b, expected 0 10 02 10", tmo, g, a, a_o);
    end
    last_win = 1;
  endtask

  task automatic test_fairness();
    logic [1:0] g, a_o, ga; logic rw, e; logic [AW-1:0] a; logic [DW-1:0] d, r; int early; bit tmo;
    int w;
    set_src(0, 1'b1, 6'h0A, 20'h0AAAA);
    set_src(1, 1'b0, 6'h0B, 20'h0BBBB);
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      w = model_winner(2'b11, last_win);
      serve(1 + i, 20'h0, (i == 3) ? 2'b11 : 2'b00, g, rw, a, d, a_o, e, r, ga, early, tmo);
      checks++;
      if (tmo || g !== 2'(1 << w) || a_o !== 2'(1 << w) || a !== ((w == 0) ? 6'h0A : 6'h0B)) begin
        errors++;
        $display("FAIL fair_%0d: got tmo=%0d grant=%b ack=%b addr=%h, expected winner %0d", i, tmo, g, a_o, a, w);
      end
      last_win = w;
    end
  endtask

  task automatic test_random();
    logic [1:0] g, a_o, ga, pat; logic rw, e; logic [AW-1:0] a; logic [DW-1:0] d, r, rd; int early; bit tmo;
    logic [AW-1:0] ea [2]; logic [DW-1:0] ed [2]; logic erw [2];
    int w;
    for (int i = 0; i < 24; i++) begin
      for (int n = 0; n < 2; n++) begin
        erw[n] = 1'($urandom); ea[n] = AW'($urandom); ed[n] = DW'($urandom);
        set_src(n, erw[n], ea[n], ed[n]);
      end
      pat = 2'($urandom_range(1, 3));
      rd  = DW'($urandom);
      w   = model_winner(pat, last_win);
      req = pat;
      serve($urandom_range(1, 8), rd, 2'b11, g, rw, a, d, a_o, e, r, ga, early, tmo);
      checks++;
      if (tmo || g !== 2'(1 << w) || rw !== erw[w] || a !== ea[w] || d !== ed[w]) begin
        errors++;
        $display("FAIL rand_latch_%0d: got tmo=%0d grant=%b rw=%b addr=%h wdata=%h, expected grant=%b rw=%b addr=%h wdata=%h",
                 i, tmo, g, rw, a, d, 2'(1 << w), erw[w], ea[w], ed[w]);
      end
      checks++;
      if (a_o !== 2'(1 << w) || e !== 1'b0 || r !== rd || early != 0 || ga !== 2'b00) begin
        errors++;
        $display("FAIL rand_resp_%0d: got ack=%b err=%b rdata=%h stray=%0d grant_after=%b, expected ack=%b err=0 rdata=%h stray=0 grant_after=00",
                 i, a_o, e, r, early, ga, 2'(1 << w), rd);
      end
      last_win = w;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [1:0] g, a_o, ga; logic rw, e; logic [AW-1:0] a; logic [DW-1:0] d, r; int early; bit tmo;
    int n, stray;
    set_src(0, 1'b0, 6'h2C, 20'hC0FFE);
    req = 2'b01; n = 0;
    do begin @(negedge clk); n++; end while (!spi_start && n < 60);
    checks++;
    if (!spi_start) begin errors++; $display("FAIL rstwait_start: no o_spi_start seen, expected one"); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({ack, err, rdata, grant, spi_start, spi_rw, spi_addr, spi_wdata} !== '0) begin
      errors++;
      $display("FAIL rstwait_outputs: got ack=%b grant=%b addr=%h wdata=%h rdata=%h, expected all zero",
               ack, grant, spi_addr, spi_wdata, rdata);
    end
    req = '0; stray = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ack != 2'b00) stray++;
    end
    rst = 1'b0;
    last_win = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ack != 2'b00) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL rstwait_noack: got %0d acks, expected 0", stray); end
    set_src(0, 1'b1, 6'h07, 20'h00777);
    req = 2'b01;
    serve(5, 20'hBEEF1, 2'b11, g, rw, a, d, a_o, e, r, ga, early, tmo);
    checks++;
    if (tmo || {g, rw, a, a_o, r} !== {2'b01, 1'b1, 6'h07, 2'b01, 20'hBEEF1}) begin
      errors++;
      $display("FAIL rstwait_after: got tmo=%0d grant=%b rw=%b addr=%h ack=%b rdata=%h, expected 0 01 1 07 01 beef1",
               tmo, g, rw, a, a_o, r);
    end
    last_win = 0;
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n, k;
    set_src(1, 1'b1, 6'h11, 20'h0);
    req = 2'b10; n = 0; k = 0;
    do begin @(negedge clk); n++; end while (!spi_start && n < 60);
    do begin @(negedge clk); k++; end while (ack == 2'b00 && k < 100);
    checks++;
    if (k != TMO + 1) begin
      errors++; $display("FAIL timeout_latency: got ack %0d cycles after start, expected %0d", k, TMO + 1);
    end
    checks++;
    if ({ack, err, rdata} !== {2'b10, 1'b1, 20'hFFFFF}) begin
      errors++; $display("FAIL timeout_resp: got ack=%b err=%b rdata=%h, expected 10 1 fffff", ack, err, rdata);
    end
    req = '0;
    repeat (2) @(negedge clk);
    last_win = 1;
  endtask
`else
  task automatic test_timeout();
    logic [1:0] g, a_o, ga; logic rw, e; logic [AW-1:0] a; logic [DW-1:0] d, r; int early; bit tmo;
    set_src(1, 1'b1, 6'h11, 20'h0);
    req = 2'b10;
    serve(3 * TMO, 20'h54321, 2'b11, g, rw, a, d, a_o, e, r, ga, early, tmo);
    checks++;
    if (tmo || early != 0 || {a_o, e, r} !== {2'b10, 1'b0, 20'h54321}) begin
      errors++;
      $display("FAIL long_wait: got tmo=%0d stray=%0d ack=%b err=%b rdata=%h, expected 0 0 10 0 54321",
               tmo, early, a_o, e, r);
    end
    last_win = 1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_tie_after_reset();
    test_fairness();
    test_random();
    test_reset_mid_wait();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/spi_req_arbiter.md
# spi_req_arbiter

Shares the single SPI master between two command sources: requester 0 is the UART command path and requester 1 is the periodic register-poll/init sequencer. The block grants the SPI master to one requester at a time, using round-robin order. It latches the granted request, issues one SPI transaction and waits for completion. It then returns read data and an acknowledge to the winner. It sits between the command front-ends and the SPI master, and is the only driver of the master's start/rw/address/data inputs.

## Interface
- SPI_ADDR_WIDTH, 6, SPI register address width
- SPI_DATA_WIDTH, 20, SPI data word width
- TIMEOUT_CYCLES, 4096, WAIT-state watchdog limit in i_clk_sys cycles (used only with SPI_ARB_TIMEOUT_EN)
- i_clk_sys  in  1  system clock; all logic on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_req  in  2  per-requester request level; held high until matching o_ack
- i_req_rw  in  2  per-requester direction, 0 = write, 1 = read
- i_req_addr  in  2*SPI_ADDR_WIDTH  packed addresses, requester n at [n*W +: W]
- i_req_wdata  in  2*SPI_DATA_WIDTH  packed write data, same packing
- o_ack  out  2  one-cycle completion pulse to the granted requester
- o_err  out  1  one-cycle pulse coincident with o_ack on timeout
- o_rdata  out  SPI_DATA_WIDTH  read result, valid in the o_ack cycle
- o_grant  out  2  one-hot owner, held from ISSUE through RESP
- o_spi_start  out  1  one-cycle transaction start pulse
- o_spi_rw  out  1  latched direction
- o_spi_addr  out  SPI_ADDR_WIDTH  latched address
- o_spi_wdata  out  SPI_DATA_WIDTH  latched write data
- i_spi_done  in  1  one-cycle pulse from the SPI master at transaction end
- i_spi_rdata  in  SPI_DATA_WIDTH  master read data, valid with i_spi_done

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any i_req bit is high, pick the winner and latch its rw/addr/wdata into the o_spi_* registers. Record the winner in last_grant, then go to ISSUE.
- Arbitration is round-robin. With both requests high, the requester not equal to last_grant wins. last_grant resets to 1, so requester 0 wins the first tie. A single request wins unconditionally.
- ISSUE: assert o_spi_start for exactly one cycle, then go to WAIT.
- WAIT: on i_spi_done, capture i_spi_rdata into o_rdata (writes also capture it; the value is don't-care to the requester), then go to RESP.
- RESP: pulse o_ack[grant] for one cycle, clear o_grant on exit, and return to IDLE.
- i_req is sampled only in IDLE. Requesters must deassert in the cycle after o_ack. A request still high in the IDLE cycle after RESP is treated as a new transaction.
- A request dropped before grant is lost without an ack. Request changes after latching are ignored.
- If i_spi_done fires in IDLE or ISSUE, it is ignored.
- Reset values: o_ack = 0, o_err = 0, o_rdata = 0, o_grant = 0, o_spi_start = 0, o_spi_rw = 0, o_spi_addr = 0, o_spi_wdata = 0, state = IDLE.
- Reset asserted mid-transaction returns the block to IDLE immediately with no ack. The SPI master shares the same reset.

## Timing
- Request high in IDLE at cycle N: latch at edge N+1, o_spi_start high during cycle N+1, WAIT from N+2.
- i_spi_done high in cycle M: o_ack and o_rdata valid in cycle M+1, IDLE in M+2.
- Minimum request-to-ack time is 3 cycles plus the SPI master latency.
- Back-to-back service: the next grant is taken in the IDLE cycle after RESP, so there is at least one idle cycle between transactions.
- All outputs are registered.

## Configuration
- SPI_ARB_TIMEOUT_EN defined: a counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES - 1 without i_spi_done, the block goes to RESP with o_rdata = all ones and o_err pulsed alongside o_ack. If i_spi_done and the expiry occur in the same cycle, done wins and o_err = 0.
- SPI_ARB_TIMEOUT_EN undefined: no counter exists, WAIT waits indefinitely, and o_err is tied to 0.

## Structure
- Shared package spi_arb_pkg holds the state enum encoding (IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3) and the NUM_REQ = 2 constant.
- One sub-module, spi_arb_rr_pick: combinational 2-way round-robin picker with inputs req and last_grant and output one-hot grant. The FSM and latches stay in the top module.

## Test plan
- Single write: req0 with rw = 0, addr = 0x15, wdata = 0xABCDE -> one o_spi_start with those values; i_spi_done 10 cycles later -> o_ack = 01 one cycle later, o_err = 0.
- Single read: req1 with rw = 1, addr = 0x3F; master returns 0x12345 -> o_rdata = 0x12345 with o_ack = 10.
- Tie after reset: both requests high from cycle 0 -> requester 0 is served first, then requester 1, with no other transaction between them.
- Fairness: hold both requests high for 4 transactions -> grants alternate 0, 1, 0, 1.
- Reset mid-WAIT: assert i_rst during WAIT -> all outputs return to 0 and no ack is issued; after release, a fresh req0 is served normally.
- Timeout (macro on, TIMEOUT_CYCLES = 16): never pulse i_spi_done -> o_ack with o_err = 1 and o_rdata = 0xFFFFF exactly 16 cycles after WAIT entry.
